// File: rtl/seven_seg_mux_driver.sv
// rtl/seven_seg_mux_driver.sv - multi-digit multiplexed seven-segment driver with dp and leading-zero blanking
module seven_seg_mux_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    OutPortIn,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_en,
    input  logic                    lz_blank,
    output logic [7:0]              outputt,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IW-1:0]           digit_idx
);

    localparam int PW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int ND2 = 1 << IW;
    localparam int DW2 = 4 * ND2;

    logic [4*NUM_DIGITS-1:0] hold_data, nxt_data;
    logic [NUM_DIGITS-1:0]   hold_dp, nxt_dp;
    logic [PW-1:0]           pcnt, nxt_pcnt;
    logic [IW-1:0]           idx, nxt_idx;
    logic [DW2-1:0]          data_pad;
    logic [ND2-1:0]          dp_pad;
    logic [ND2-1:0]          nz_above;
    logic                    acc;
    logic [3:0]              nib;
    logic                    blank;
    logic [NUM_DIGITS-1:0]   nxt_an;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s[6:0];
    endfunction

    always_comb begin
        nxt_data = OutPortIn ? data  : hold_data;
        nxt_dp   = OutPortIn ? dp_en : hold_dp;
        nxt_pcnt = pcnt + 1'b1;
        nxt_idx  = idx;
        if (pcnt == PW'(REFRESH_DIV - 1)) begin
            nxt_pcnt = '0;
            nxt_idx  = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end

        // Padded to a power of two so a variable index can never select past the vector.
        data_pad = DW2'(nxt_data);
        dp_pad   = ND2'(nxt_dp);

        // nz_above[k] is set when any nibble at position k or higher is nonzero.
        acc      = 1'b0;
        nz_above = '0;
        for (int k = ND2 - 1; k >= 0; k--) begin
            acc         = acc | (data_pad[4*k +: 4] != 4'h0);
            nz_above[k] = acc;
        end

        nib    = data_pad[4*nxt_idx +: 4];
        blank  = lz_blank && (nxt_idx != '0) && !nz_above[nxt_idx];
        nxt_an = ~(NUM_DIGITS'(1) << nxt_idx);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            hold_data <= '0;
            hold_dp   <= '0;
            pcnt      <= '0;
            idx       <= '0;
            outputt   <= 8'hFF;
            an        <= '1;
            digit_idx <= '0;
        end else begin
            hold_data <= nxt_data;
            hold_dp   <= nxt_dp;
            pcnt      <= nxt_pcnt;
            idx       <= nxt_idx;
            outputt   <= {~dp_pad[nxt_idx], blank ? 7'h7F : hex7(nib)};
            an        <= nxt_an;
            digit_idx <= nxt_idx;
        end
    end

endmodule
